// File: rtl/countdown_pkg.sv
// Shared types and default widths for the countdown timer.
// Build option COUNTDOWN_AUTO_RELOAD_EN is consumed by countdown_timer only.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    localparam int CD_WIDTH      = 16;
    localparam int CD_PRESCALE_W = 8;

endpackage

// File: rtl/countdown_prescaler.sv
// Prescaler for the countdown timer: emits a tick when the running count matches PRE.
// The compare uses the registered count, so the tick is known early in the cycle.
module countdown_prescaler
    import countdown_pkg::*;
#(
    parameter int PRESCALE_W = CD_PRESCALE_W
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  clr,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] PRE,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == PRE);

    // If PRE drops below cnt_q the count runs up to all-ones and wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_ONE;
        end
    end

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, pause/resume and stop-at-zero DONE flag.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic reload with a one-cycle DONE pulse.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH      = CD_WIDTH,
    parameter int PRESCALE_W = CD_PRESCALE_W
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ST,
    input  logic [WIDTH-1:0]      X,
    input  logic                  GO,
    input  logic                  STOP,
    input  logic                  ACK,
    input  logic [PRESCALE_W-1:0] PRE,
    output logic [WIDTH-1:0]      OUT,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] eff_out;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pre_en;
    logic             tick;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic done_pulse;
    logic unused_ack;
    assign unused_ack = ACK;
`endif

    // The prescaler only advances on cycles where RUN is not pre-empted by ST or STOP.
    assign pre_en = (state_q == RUN) && !ST && !STOP;

    countdown_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (ST),
        .en    (pre_en),
        .PRE   (PRE),
        .tick  (tick)
    );

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        eff_out  = ST ? X : out_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        done_pulse = 1'b0;
`endif
        if (ST) begin
            reload_d = X;
            out_d    = X;
        end

        if (GO && state_q == IDLE) begin
            if (eff_out == '0) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                done_pulse = 1'b1;
`else
                state_d = EXPIRED;
`endif
            end else begin
                state_d = RUN;
            end
        end else if (state_q == RUN && !ST) begin
            if (STOP) begin
                state_d = IDLE;
            end else if (tick) begin
                if (out_q > ONE) begin
                    out_d = out_q - ONE;
                end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    out_d      = reload_q;
                    done_pulse = 1'b1;
                    if (reload_q == '0) begin
                        state_d = IDLE;
                    end
`else
                    out_d   = '0;
                    state_d = EXPIRED;
`endif
                end
            end
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        end else if (state_q == EXPIRED && ACK && !ST) begin
            state_d = IDLE;
`endif
        end

        busy_d = (state_d == RUN);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        done_d = done_pulse;
`else
        done_d = (state_d == EXPIRED);
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            out_q    <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign OUT  = out_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus randomized traffic
// against a behavioural model; honours COUNTDOWN_AUTO_RELOAD_EN when defined.
module tb_countdown_timer;

    localparam int W  = 16;
    localparam int PW = 8;

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b0;
    logic          ST    = 1'b0;
    logic          GO    = 1'b0;
    logic          STOP  = 1'b0;
    logic          ACK   = 1'b0;
    logic [W-1:0]  X     = '0;
    logic [PW-1:0] PRE   = '0;
    logic [W-1:0]  OUT;
    logic          BUSY;
    logic          DONE;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: count value, reload value, cycles into the current prescale period.
    int m_out;
    int m_reload;
    int m_phase;
    bit m_run;
    bit m_exp;
    bit m_pulse;

    int r;
    int x_i;
    int pulses;
    bit st_i, go_i, stop_i, ack_i;

    always #5 CLK = ~CLK;

    countdown_timer #(
        .WIDTH      (W),
        .PRESCALE_W (PW)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .ST    (ST),
        .X     (X),
        .GO    (GO),
        .STOP  (STOP),
        .ACK   (ACK),
        .PRE   (PRE),
        .OUT   (OUT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_out    = 0;
        m_reload = 0;
        m_phase  = 0;
        m_run    = 0;
        m_exp    = 0;
        m_pulse  = 0;
    endtask

    task automatic model_start();
        if (m_out == 0) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            m_pulse = 1;
`else
            m_exp = 1;
`endif
        end else begin
            m_run = 1;
        end
    endtask

    task automatic model_count_down();
        if (m_out > 1) begin
            m_out = m_out - 1;
        end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            m_pulse = 1;
            m_out   = m_reload;
            if (m_reload == 0) m_run = 0;
`else
            m_out = 0;
            m_run = 0;
            m_exp = 1;
`endif
        end
    endtask

    // Applies one clock edge of the timer's rules to the model, using the inputs seen at that edge.
    task automatic model_edge();
        m_pulse = 0;
        if (!RST_N) begin
            model_reset();
        end else begin
            if (ST) begin
                m_reload = int'(X);
                m_out    = int'(X);
                m_phase  = 0;
            end
            if (GO && !m_run && !m_exp) begin
                model_start();
            end else if (m_run && !ST) begin
                if (STOP) begin
                    m_run = 0;
                end else if (m_phase == int'(PRE)) begin
                    m_phase = 0;
                    model_count_down();
                end else begin
                    m_phase = (m_phase + 1) % (1 << PW);
                end
            end else if (m_exp && ACK && !ST) begin
                m_exp = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_out"},  32'(OUT),  32'(m_out));
        check({tag, "_busy"}, 32'(BUSY), 32'(m_run));
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        check({tag, "_done"}, 32'(DONE), 32'(m_pulse));
`else
        check({tag, "_done"}, 32'(DONE), 32'(m_exp));
`endif
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic cyc(input string tag, input bit st_v, input int x_v,
                       input bit go_v, input bit stop_v, input bit ack_v);
        ST   = st_v;
        if (st_v) X = x_v[W-1:0];
        GO   = go_v;
        STOP = stop_v;
        ACK  = ack_v;
        step(tag);
        ST   = 1'b0;
        GO   = 1'b0;
        STOP = 1'b0;
        ACK  = 1'b0;
    endtask

    initial begin
        model_reset();
        RST_N = 1'b0;
        #12;
        check("rst_out",  32'(OUT),  32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        step("post_rst");

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // X=3, PRE=0: OUT 2,1,0 on the three edges after GO, DONE held until ACK.
        PRE = '0;
        cyc("ld3", 1'b1, 3, 1'b0, 1'b0, 1'b0);
        cyc("go3", 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("go3_busy", 32'(BUSY), 32'd1);
        step("x3_a");
        step("x3_b");
        check("x3_done_early", 32'(DONE), 32'd0);
        step("x3_c");
        check("x3_done", 32'(DONE), 32'd1);
        check("x3_zero", 32'(OUT), 32'd0);
        cyc("ack3", 1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("ack3_done", 32'(DONE), 32'd0);
        check("ack3_busy", 32'(BUSY), 32'd0);

        // X=2, PRE=4: decrement every 5 cycles, DONE at n+10, no wrap afterwards.
        PRE = 8'd4;
        cyc("ld2", 1'b1, 2, 1'b0, 1'b0, 1'b0);
        cyc("go2", 1'b0, 0, 1'b1, 1'b0, 1'b0);
        repeat (9) step("p4");
        check("p4_out_n9",  32'(OUT),  32'd1);
        check("p4_done_n9", 32'(DONE), 32'd0);
        step("p4_n10");
        check("p4_done_n10", 32'(DONE), 32'd1);
        repeat (20) step("p4_hold");
        check("p4_nowrap", 32'(OUT), 32'd0);
        cyc("ack2", 1'b0, 0, 1'b0, 1'b0, 1'b1);

        // X=10, PRE=0: STOP at OUT=6, hold 8 cycles, resume to DONE 6 edges after GO.
        PRE = '0;
        cyc("ld10", 1'b1, 10, 1'b0, 1'b0, 1'b0);
        cyc("go10", 1'b0, 0, 1'b1, 1'b0, 1'b0);
        repeat (4) step("run10");
        check("stop_at6", 32'(OUT), 32'd6);
        cyc("stop10", 1'b0, 0, 1'b0, 1'b1, 1'b0);
        repeat (8) step("paused");
        check("pause_out",  32'(OUT),  32'd6);
        check("pause_busy", 32'(BUSY), 32'd0);
        cyc("resume", 1'b0, 0, 1'b1, 1'b0, 1'b0);
        repeat (5) step("resumed");
        check("resume_done_early", 32'(DONE), 32'd0);
        step("resume_end");
        check("resume_done", 32'(DONE), 32'd1);
        cyc("ack10", 1'b0, 0, 1'b0, 1'b0, 1'b1);

        // X=0 with GO on the same edge: straight to EXPIRED.
        cyc("zero_go", 1'b1, 0, 1'b1, 1'b0, 1'b0);
        check("zero_done", 32'(DONE), 32'd1);
        check("zero_busy", 32'(BUSY), 32'd0);
        cyc("zero_ack", 1'b0, 0, 1'b0, 1'b0, 1'b1);
`else
        // X=4, PRE=1: DONE pulse every 8 cycles; reload to X=2 gives one every 4.
        PRE = 8'd1;
        cyc("ar_ld4", 1'b1, 4, 1'b0, 1'b0, 1'b0);
        cyc("ar_go4", 1'b0, 0, 1'b1, 1'b0, 1'b0);
        pulses = 0;
        repeat (24) begin
            step("ar4");
            if (DONE === 1'b1) pulses++;
        end
        check("ar4_pulses", 32'(pulses), 32'd3);
        cyc("ar_ld2", 1'b1, 2, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        repeat (16) begin
            step("ar2");
            if (DONE === 1'b1) pulses++;
        end
        check("ar2_pulses", 32'(pulses), 32'd4);
        cyc("ar_stop", 1'b0, 0, 1'b0, 1'b1, 1'b0);
        cyc("ar_zero", 1'b1, 0, 1'b1, 1'b0, 1'b0);
        check("ar_zero_done", 32'(DONE), 32'd1);
        step("ar_zero_after");
        check("ar_zero_fall", 32'(DONE), 32'd0);
`endif

        // Reset mid-run at OUT=57: asynchronous clear, no counting while held.
        PRE = '0;
        cyc("ld100", 1'b1, 100, 1'b0, 1'b0, 1'b0);
        cyc("go100", 1'b0, 0, 1'b1, 1'b0, 1'b0);
        repeat (43) step("run100");
        check("pre_rst_out", 32'(OUT), 32'd57);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        check("async_rst_out",  32'(OUT),  32'd0);
        check("async_rst_busy", 32'(BUSY), 32'd0);
        check("async_rst_done", 32'(DONE), 32'd0);
        repeat (3) step("rst_held");
        RST_N = 1'b1;
        step("rst_release");

        // Randomized traffic: ST/GO/STOP/ACK mixes checked every cycle against the model.
        for (int i = 0; i < 300; i++) begin
            r      = int'($urandom_range(0, 99));
            st_i   = 1'b0;
            go_i   = 1'b0;
            stop_i = 1'b0;
            ack_i  = 1'b0;
            x_i    = 0;
            if (!m_run && !m_exp && r < 10) begin
                PRE = PW'($urandom_range(0, 3));
            end else if (r >= 10 && r < 18) begin
                st_i = 1'b1;
                x_i  = m_run ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 12));
                go_i = 1'($urandom_range(0, 1));
            end else if (r >= 18 && r < 35) begin
                go_i = 1'b1;
            end else if (r >= 35 && r < 42 && PRE == '0) begin
                stop_i = 1'b1;
            end else if (r >= 42 && r < 55) begin
                ack_i = 1'b1;
            end
            cyc("rnd", st_i, x_i, go_i, stop_i, ack_i);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
